// File: rtl/alu_muldiv_iter_if.sv
// Handshake and operand/result bundle for the iterative multiply/divide unit.
interface alu_muldiv_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    // Requester side (ALU control).
    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, div_by_zero
    );

    // Unit side.
    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one hi/lo register pair, one bit per clock. Operands are
// reduced to magnitudes on accept and the sign is restored in the DONE state.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_muldiv_iter_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;          // negate product / quotient
    logic             neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
    logic             b_zero_q, b_zero_d;
    logic             ovf_q, ovf_d;          // most-negative / -1
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;            // partial product high / remainder
    logic [WIDTH-1:0] lo_q, lo_d;            // multiplier / dividend->quotient
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;

    // Datapath temporaries
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            ovf_q     <= 1'b0;
            a_orig_q  <= '0;
            b_mag_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            ovf_q     <= ovf_d;
            a_orig_q  <= a_orig_d;
            b_mag_q   <= b_mag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
        end
    end

    // Next-state logic: accept, iterate, then sign-correct and publish.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        ovf_d     = ovf_q;
        a_orig_d  = a_orig_q;
        b_mag_d   = b_mag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;

        a_neg     = bus.op[0] & bus.a[WIDTH-1];
        b_neg     = bus.op[0] & bus.b[WIDTH-1];
        a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
        b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;
        add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : '0);
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_mag_q};
        prod      = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
        quo       = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem       = neg_rem_q ? (~hi_q + 1'b1) : hi_q;

        unique case (state_q)
            StIdle: begin
                // The done cycle still counts as busy, so start is ignored there.
                if (bus.start && !done_q) begin
                    state_d   = StRun;
                    count_d   = CntW'(WIDTH);
                    is_div_d  = bus.op[1];
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    b_zero_d  = (bus.b == '0);
                    ovf_d     = bus.op[0] && (bus.a == MinNeg) && (bus.b == '1);
                    a_orig_d  = bus.a;
                    b_mag_d   = b_mag;
                    hi_d      = '0;
                    lo_d      = a_mag;
                end
            end
            StRun: begin
                count_d = count_q - CntW'(1);
                if (is_div_q) begin
                    // Restoring step: keep the subtraction only if it did not borrow.
                    if (!rem_diff[WIDTH]) begin
                        hi_d = rem_diff[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = rem_shift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
                end
                if (count_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b1;
                dbz_d   = 1'b0;
                if (!is_div_q) begin
                    // Negating a zero product yields zero, so no extra guard needed.
                    {res_hi_d, res_lo_d} = prod;
                end else if (b_zero_q) begin
                    res_lo_d = '1;
                    res_hi_d = a_orig_q;
                    dbz_d    = 1'b1;
                end else if (ovf_q) begin
                    res_lo_d = a_orig_q;
                    res_hi_d = '0;
                end else begin
                    res_lo_d = quo;
                    res_hi_d = rem;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy        = (state_q != StIdle) || done_q;
    assign bus.done        = done_q;
    assign bus.result_lo   = res_lo_q;
    assign bus.result_hi   = res_hi_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Scoreboard bench for alu_muldiv_iter: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_muldiv_iter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_muldiv_iter_if #(.WIDTH(32)) bus ();

    alu_muldiv_iter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_lo", 64'(bus.result_lo), 64'(e.lo));
                check("result_hi", 64'(bus.result_hi), 64'(e.hi));
                check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
            end
        end
    end

    // Issue one op, check latency and busy; optionally poke start while busy.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input logic edbz,
                         input bit poke);
        exp_t e;
        int   cyc;
        bit   seen;
        bit   busy_drop;
        @(negedge clk);
        for (int i = 0; i < 50 && bus.busy === 1'b1; i++) @(negedge clk);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        e.lo = elo;
        e.hi = ehi;
        e.dbz = edbz;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEADBEEF;
        bus.b     = 32'h0;
        bus.op    = ~op;
        cyc = 0;
        seen = 1'b0;
        busy_drop = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_drop = 1'b1;
            if (bus.done === 1'b1) seen = 1'b1;
            if (poke && cyc == 5) begin
                bus.start = 1'b1;
                bus.op    = 2'b00;
                bus.a     = 32'h0000_0011;
                bus.b     = 32'h0000_0013;
            end else if (poke && seen) begin
                bus.start = 1'b1;
                bus.op    = 2'b10;
                bus.a     = 32'h0000_0100;
                bus.b     = 32'h0000_0000;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(cyc), 64'd33);
        check("busy_held", 64'(busy_drop), 64'd0);
        if (poke) begin
            bit busy_again;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            busy_again = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.busy !== 1'b0) busy_again = 1'b1;
            end
            check("ignored_start", 64'(busy_again), 64'd0);
            check("held_lo", 64'(bus.result_lo), 64'(elo));
            check("held_hi", 64'(bus.result_hi), 64'(ehi));
        end
    endtask

    initial begin
        bit stray;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_lo", 64'(bus.result_lo), 64'd0);
        check("rst_hi", 64'(bus.result_hi), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        rst = 1'b0;

        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        issue(2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(2'b01, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
        issue(2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0);
        issue(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(2'b11, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0);
        issue(2'b10, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0);
        issue(2'b10, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b0);
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
        issue(2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0);
        issue(2'b10, 32'h0000000A, 32'h00000003, 32'h00000003, 32'h00000001, 1'b0, 1'b0);
        issue(2'b00, 32'h00000006, 32'h00000007, 32'h0000002A, 32'h00000000, 1'b0, 1'b1);

        // Abort an operation mid-iteration; no done may follow.
        @(negedge clk);
        bus.op    = 2'b00;
        bus.a     = 32'h7;
        bus.b     = 32'h9;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_lo", 64'(bus.result_lo), 64'd0);
        check("abort_hi", 64'(bus.result_hi), 64'd0);
        check("abort_dbz", 64'(bus.div_by_zero), 64'd0);
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) stray = 1'b1;
        end
        check("abort_quiet", 64'(stray), 64'd0);

        issue(2'b00, 32'h00000003, 32'h00000005, 32'h0000000F, 32'h00000000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
